// File: rtl/addsub_result_stage.sv
// Result stage behind a multi-word adder: 2-entry skid FIFO with chain-wide zero flag and carry
// feedback. Define ADDSUB_RESULT_STICKY_OVERFLOW_EN to make out_overflow sticky across a chain.
module addsub_result_stage #(
  parameter int WORD_WIDTH = 0,
  // Clamp keeps an unconfigured (illegal) default elaborating to a sane shape
  localparam int Width = (WORD_WIDTH < 2) ? 2 : WORD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_sum,
  input  logic             in_carry_out,
  input  logic             in_sub_add,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  input  logic             in_chain_last,
  output logic             carry_feedback,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_sum,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_negative,
  output logic             out_overflow
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  typedef struct packed {
    logic [Width-1:0] sum;
    logic             carry;
    logic             zero;
    logic             negative;
    logic             overflow;
  } entry_t;

  state_e           state_q, state_d;
  entry_t [1:0]     mem_q, mem_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             carry_fb_q, carry_fb_d;
  logic             zero_seed_q, zero_seed_d;
`ifdef ADDSUB_RESULT_STICKY_OVERFLOW_EN
  logic             ovf_acc_q, ovf_acc_d;
`endif

  logic   push, pop;
  logic   sum_msb, word_ovf, word_zero, chain_ovf;
  entry_t new_entry;
  entry_t head;

  assign push    = in_valid & in_ready_q;
  assign pop     = out_valid_q & out_ready;
  assign sum_msb = in_sum[Width-1];

  always_comb begin
    word_ovf  = in_sub_add ? ((in_a_msb != in_b_msb) && (sum_msb != in_a_msb))
                           : ((in_a_msb == in_b_msb) && (sum_msb != in_a_msb));
    word_zero = zero_seed_q & (in_sum == '0);
`ifdef ADDSUB_RESULT_STICKY_OVERFLOW_EN
    chain_ovf = ovf_acc_q | word_ovf;
`else
    chain_ovf = word_ovf;
`endif
    new_entry.sum      = in_sum;
    new_entry.carry    = in_carry_out;
    new_entry.zero     = word_zero;
    new_entry.negative = sum_msb;
    new_entry.overflow = chain_ovf;
  end

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    carry_fb_d  = carry_fb_q;
    zero_seed_d = zero_seed_q;
`ifdef ADDSUB_RESULT_STICKY_OVERFLOW_EN
    ovf_acc_d   = ovf_acc_q;
`endif

    unique case (state_q)
      StEmpty: if (push) state_d = StOne;
      StOne: begin
        if (push && !pop)      state_d = StFull;
        else if (!push && pop) state_d = StEmpty;
      end
      StFull:  if (pop) state_d = StOne;
      default: state_d = StEmpty;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = ~wr_ptr_q;
      carry_fb_d      = in_chain_last ? 1'b0 : in_carry_out;
      // A closed chain reseeds so the next word starts a fresh all-zero run
      zero_seed_d     = in_chain_last ? 1'b1 : word_zero;
`ifdef ADDSUB_RESULT_STICKY_OVERFLOW_EN
      ovf_acc_d       = in_chain_last ? 1'b0 : chain_ovf;
`endif
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    in_ready_d  = (state_d != StFull);
    out_valid_d = (state_d != StEmpty);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      mem_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      carry_fb_q  <= 1'b0;
      zero_seed_q <= 1'b1;
`ifdef ADDSUB_RESULT_STICKY_OVERFLOW_EN
      ovf_acc_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      carry_fb_q  <= carry_fb_d;
      zero_seed_q <= zero_seed_d;
`ifdef ADDSUB_RESULT_STICKY_OVERFLOW_EN
      ovf_acc_q   <= ovf_acc_d;
`endif
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign carry_feedback = carry_fb_q;
  assign out_sum        = head.sum;
  assign out_carry      = head.carry;
  assign out_zero       = head.zero;
  assign out_negative   = head.negative;
  assign out_overflow   = head.overflow;

endmodule

// File: tb/tb_addsub_result_stage.sv
// Self-checking bench for addsub_result_stage: queue-based reference model compared every
// negedge, plus hand-computed literal expectations for the directed scenarios.
module tb_addsub_result_stage;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid, in_ready, in_carry_out, in_sub_add, in_a_msb, in_b_msb, in_chain_last;
  logic [W-1:0] in_sum, out_sum;
  logic         carry_feedback, out_valid, out_ready;
  logic         out_carry, out_zero, out_negative, out_overflow;

  addsub_result_stage #(.WORD_WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sum         (in_sum),
    .in_carry_out   (in_carry_out),
    .in_sub_add     (in_sub_add),
    .in_a_msb       (in_a_msb),
    .in_b_msb       (in_b_msb),
    .in_chain_last  (in_chain_last),
    .carry_feedback (carry_feedback),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sum        (out_sum),
    .out_carry      (out_carry),
    .out_zero       (out_zero),
    .out_negative   (out_negative),
    .out_overflow   (out_overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected FIFO contents and the words of the chain in progress
  typedef struct {
    logic [W-1:0] sum;
    logic carry, zero, neg, ovf;
  } exp_t;

  exp_t         mq[$];
  logic [W-1:0] chain_sums[$];
  bit           chain_ovfs[$];
  logic         mcf = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      chain_sums.delete();
      chain_ovfs.delete();
      mcf = 1'b0;
    end else begin : upd
      bit   push, pop, w_ovf;
      exp_t e;
      push = in_valid && (mq.size() < 2);
      pop  = out_ready && (mq.size() > 0);
      if (pop) void'(mq.pop_front());
      if (push) begin
        w_ovf = in_sub_add ? ((in_a_msb != in_b_msb) && (in_sum[W-1] != in_a_msb))
                           : ((in_a_msb == in_b_msb) && (in_sum[W-1] != in_a_msb));
        chain_sums.push_back(in_sum);
        chain_ovfs.push_back(w_ovf);
        e.sum   = in_sum;
        e.carry = in_carry_out;
        e.neg   = in_sum[W-1];
        e.zero  = 1'b1;
        foreach (chain_sums[i]) if (chain_sums[i] != '0) e.zero = 1'b0;
`ifdef ADDSUB_RESULT_STICKY_OVERFLOW_EN
        e.ovf = 1'b0;
        foreach (chain_ovfs[i]) if (chain_ovfs[i]) e.ovf = 1'b1;
`else
        e.ovf = w_ovf;
`endif
        mq.push_back(e);
        mcf = in_chain_last ? 1'b0 : in_carry_out;
        if (in_chain_last) begin
          chain_sums.delete();
          chain_ovfs.delete();
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("out_valid", out_valid, mq.size() != 0);
      check("in_ready", in_ready, mq.size() < 2);
      check("carry_feedback", carry_feedback, mcf);
      if (mq.size() > 0) begin
        check("out_sum", out_sum, mq[0].sum);
        check("out_carry", out_carry, mq[0].carry);
        check("out_zero", out_zero, mq[0].zero);
        check("out_negative", out_negative, mq[0].neg);
        check("out_overflow", out_overflow, mq[0].ovf);
      end
    end
  end

  // Presents one word (adder result computed here) and returns at the negedge after acceptance
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input logic last);
    logic [W:0] r;
    logic       acc;
    r = sub ? ({1'b0, a} + {1'b0, ~b} + (W+1)'(1)) : ({1'b0, a} + {1'b0, b});
    in_valid      = 1'b1;
    in_sum        = r[W-1:0];
    in_carry_out  = r[W];
    in_sub_add    = sub;
    in_a_msb      = a[W-1];
    in_b_msb      = b[W-1];
    in_chain_last = last;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = in_ready;
      @(negedge clock);
    end
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: actual not accepted required accepted (t=%0t)", $time);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    int start;
    in_valid = 0; in_sum = '0; in_carry_out = 0; in_sub_add = 0;
    in_a_msb = 0; in_b_msb = 0; in_chain_last = 0; out_ready = 0;
    repeat (2) @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_carry_fb", carry_feedback, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_flags", {out_carry, out_zero, out_negative, out_overflow}, 0);
    reset = 1'b0;
    @(negedge clock);

    // 0x7F + 0x01 single-word chain
    out_ready = 1'b1;
    send(8'h7F, 8'h01, 1'b0, 1'b1);
    check("t032_valid", out_valid, 1);
    check("t032_sum", out_sum, 8'h80);
    check("t032_ovf", out_overflow, 1);
    check("t032_neg", out_negative, 1);
    check("t032_zero", out_zero, 0);
    check("t032_carry", out_carry, 0);
    idle();
    @(negedge clock);
    check("t032_drained", out_valid, 0);

    // Two-word all-zero chain with carry feedback
    send(8'h80, 8'h80, 1'b0, 1'b0);
    check("t033_cf0", carry_feedback, 1);
    check("t033_zero0", out_zero, 1);
    check("t033_carry0", out_carry, 1);
    send(8'h00, 8'h00, 1'b0, 1'b1);
    check("t033_cf1", carry_feedback, 0);
    check("t033_zero1", out_zero, 1);
    idle();
    repeat (2) @(negedge clock);

    // Backpressure: third word held until release, order preserved
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b0, 1'b0);
    check("t034_full_ready", in_ready, 0);
    check("t034_head", out_sum, 8'h33);
    fork
      send(8'h55, 8'h66, 1'b0, 1'b1);
      begin
        repeat (3) @(negedge clock);
        check("t034_held_ready", in_ready, 0);
        check("t034_head_stable", out_sum, 8'h33);
        out_ready = 1'b1;
      end
    join
    idle();
    repeat (3) @(negedge clock);

    // Streaming through ONE: one word per cycle
    start = cyc;
    for (int i = 0; i < 10; i++) send(8'(i), 8'(3 * i), 1'(i % 2), i == 9);
    check("t035_cycles", cyc - start, 10);
    check("t035_ready", in_ready, 1);
    idle();
    repeat (2) @(negedge clock);

    // Subtract overflow, then a clean word in the same chain
    send(8'h80, 8'h01, 1'b1, 1'b0);
    check("t036_sum", out_sum, 8'h7F);
    check("t036_ovf", out_overflow, 1);
    send(8'h01, 8'h01, 1'b0, 1'b0);
    check("t036_sum2", out_sum, 8'h02);
`ifdef ADDSUB_RESULT_STICKY_OVERFLOW_EN
    check("t036_ovf2", out_overflow, 1);
`else
    check("t036_ovf2", out_overflow, 0);
`endif
    send(8'h00, 8'h00, 1'b0, 1'b1);
    check("t036_zero_last", out_zero, 0);
    idle();
    repeat (2) @(negedge clock);

    // Reset while FULL mid-chain
    out_ready = 1'b0;
    send(8'h90, 8'h80, 1'b0, 1'b0);
    send(8'hF0, 8'h20, 1'b0, 1'b0);
    check("t037_cf_pre", carry_feedback, 1);
    check("t037_full", in_ready, 0);
    idle();
    #2 reset = 1'b1;
    #1;
    check("t037_valid", out_valid, 0);
    check("t037_cf", carry_feedback, 0);
    check("t037_ready", in_ready, 1);
    check("t037_sum", out_sum, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    out_ready = 1'b1;
    send(8'h00, 8'h00, 1'b0, 1'b1);
    check("t037_zero_new", out_zero, 1);
    check("t037_valid_new", out_valid, 1);
    idle();
    repeat (4) @(negedge clock);
    check("end_drained", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/addsub_result_stage.md
ADDSUB_RESULT_STAGE -- requirements
Module: addsub_result_stage

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 0, adder word width; legal values are 2 and above.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream adder result present.
REQ-005 SHALL have port in_ready  output  1  stage can accept a result.
REQ-006 SHALL have port in_sum  input  WORD_WIDTH  adder sum word.
REQ-007 SHALL have port in_carry_out  input  1  adder carry/borrow out.
REQ-008 SHALL have port in_sub_add  input  1  1/0 -> word was A-B/A+B.
REQ-009 SHALL have port in_a_msb, in_b_msb  input  1 each  operand sign bits.
REQ-010 SHALL have port in_chain_last  input  1  word is last (most significant) of a multi-word op.
REQ-011 SHALL have port carry_feedback  output  1  registered carry to drive upstream carry_in.
REQ-012 SHALL have port out_valid  output  1  result entry available.
REQ-013 SHALL have port out_ready  input  1  downstream accepts entry.
REQ-014 SHALL have ports out_sum (WORD_WIDTH), out_carry, out_zero, out_negative, out_overflow (1 each), all outputs.

Function
REQ-015 SHALL buffer results in a 2-entry FIFO (skid buffer); occupancy states EMPTY, ONE, FULL.
REQ-016 SHALL accept an input on a rising edge when in_valid and in_ready are both 1; in_ready SHALL be 1 exactly when state is not FULL, registered.
REQ-017 SHALL pop the head entry on a rising edge when out_valid and out_ready are both 1; out_valid SHALL be 1 exactly when state is not EMPTY.
REQ-018 SHALL have minimum latency 1 cycle: a word accepted at edge N appears on the outputs after edge N.
REQ-019 SHALL transition EMPTY->ONE on push only; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop; FULL->ONE on pop; FULL SHALL ignore in_valid.
REQ-020 SHALL preserve order; output fields SHALL come from the head entry and remain stable while out_valid=1 and out_ready=0.
REQ-021 SHALL compute out_negative = sum MSB of the stored word.
REQ-022 SHALL compute overflow for add as (a_msb==b_msb)&&(sum_msb!=a_msb), and for sub as (a_msb!=b_msb)&&(sum_msb!=a_msb).
REQ-023 SHALL compute out_zero as a chain-wide flag: the running AND of (sum==0) over all words since the previous chain_last, inclusive of the current word.
REQ-024 SHALL treat every accepted word with in_chain_last=1 as closing the chain; the next accepted word starts a new chain with a running-zero seed of 1.
REQ-025 SHALL set carry_feedback on each accepted word to in_carry_out if in_chain_last=0, else to 0; it SHALL hold otherwise.
REQ-026 SHALL store out_carry = in_carry_out unmodified, borrow semantics included.

Reset
REQ-027 SHALL on reset clear state to EMPTY, in_ready to 1, out_valid to 0, carry_feedback to 0, running-zero seed to 1, and all data outputs to 0.
REQ-028 SHALL on reset mid-chain or mid-transfer discard all entries and partial chain state, with no output pulse.

Configuration
REQ-029 SHALL support macro ADDSUB_RESULT_STICKY_OVERFLOW_EN.
REQ-030 With ADDSUB_RESULT_STICKY_OVERFLOW_EN defined, out_overflow SHALL be the OR of per-word overflow over the chain so far, resetting at chain start.
REQ-031 Without ADDSUB_RESULT_STICKY_OVERFLOW_EN, out_overflow SHALL be the per-word overflow of the stored word only.

Verification
REQ-032 SHALL cover WORD_WIDTH=8, add 0x7F+0x01, chain_last=1 -> out_sum 0x80, overflow 1, negative 1, zero 0, carry 0, one cycle after accept.
REQ-033 SHALL cover a 2-word chain: word0 sum 0x00, carry 1, last 0; word1 sum 0x00, last 1 -> carry_feedback 1 then 0; out_zero 1 on both entries.
REQ-034 SHALL cover out_ready held 0 with 3 valid words -> in_ready falls after 2 accepts, the 3rd is held, then order is preserved on release.
REQ-035 SHALL cover simultaneous push/pop in ONE state for 10 cycles -> continuous throughput of 1 word/cycle, in_ready stays 1.
REQ-036 SHALL cover sub 0x80-0x01 -> sum 0x7F, overflow 1; with the sticky macro, a following non-last word 0x01+0x01 still shows overflow 1.
REQ-037 SHALL cover reset asserted while FULL mid-chain -> out_valid 0, carry_feedback 0 immediately, and the next chain's zero flag is unaffected.
